// File: rtl/jk_monitor.sv
// jk_monitor: reference-model checker for an observed JK flip-flop.
// Ports: clk, reset (async active-low); observed dut_reset, dut_set, j, k, q, qbar;
//        clear_stats (sync clear of counters and fault state);
//        model_q, state (0 IDLE, 1 CHECK, 2 FAULT), err_flag, err_count,
//        toggle_count, cycle_count, first_err_cycle.
module jk_monitor #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dut_reset,
    input  logic             dut_set,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             qbar,
    input  logic             clear_stats,
    output logic             model_q,
    output logic [1:0]       state,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] first_err_cycle
);
    typedef enum logic [1:0] {IDLE, CHECK, FAULT} state_t;
    state_t st;
    // model_q is the value computed at the previous edge, so it is the
    // expectation for q sampled at this edge
    logic next_q, mismatch, toggle;
    logic [CNT_W-1:0] cc_next;
    always_comb begin
        next_q   = dut_reset ? 1'b0 : dut_set ? 1'b1 : (j & k) ? ~model_q : (j | k) ? j : model_q;
        mismatch = (st != IDLE) && (q != model_q || qbar == q);
        toggle   = j & k & ~dut_reset & ~dut_set;
        cc_next  = &cycle_count ? cycle_count : cycle_count + 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st              <= IDLE;
            model_q         <= 1'b0;
            err_count       <= '0;
            toggle_count    <= '0;
            cycle_count     <= '0;
            first_err_cycle <= '0;
        end else if (st == IDLE) begin
            if (dut_reset || dut_set) begin
                model_q <= next_q;
                st      <= CHECK;
            end
        end else begin
            model_q <= next_q;
            if (clear_stats) begin
                err_count       <= '0;
                toggle_count    <= '0;
                cycle_count     <= '0;
                first_err_cycle <= '0;
                st              <= CHECK;
            end else begin
                cycle_count <= cc_next;
                if (toggle && !(&toggle_count))
                    toggle_count <= toggle_count + 1'b1;
                if (mismatch) begin
                    if (!(&err_count))
                        err_count <= err_count + 1'b1;
                    // only the first mismatch since the last clear is recorded
                    if (st == CHECK) begin
                        first_err_cycle <= cc_next;
                        st              <= FAULT;
                    end
                end
            end
        end
    end
    assign state    = st;
    assign err_flag = (st == FAULT);
endmodule

// File: tb/tb_jk_monitor.sv
// tb_jk_monitor: table-driven scoreboard bench for jk_monitor
module tb_jk_monitor;
    logic clk = 0, reset = 0;
    logic dut_reset = 0, dut_set = 0, j = 0, k = 0, q = 0, qbar = 1, clear_stats = 0;
    logic model_q, err_flag, model_q2, err_flag2;
    logic [1:0] state, state2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic [15:0] toggle_count, cycle_count, first_err_cycle;
    logic [15:0] toggle_count2, cycle_count2, first_err_cycle2;
    int checks = 0, errors = 0;
    logic fq = 0;

    always #5 clk = ~clk;

    jk_monitor u_dut (
        .clk(clk), .reset(reset), .dut_reset(dut_reset), .dut_set(dut_set),
        .j(j), .k(k), .q(q), .qbar(qbar), .clear_stats(clear_stats),
        .model_q(model_q), .state(state), .err_flag(err_flag), .err_count(err_count),
        .toggle_count(toggle_count), .cycle_count(cycle_count), .first_err_cycle(first_err_cycle)
    );

    jk_monitor #(.ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .dut_reset(dut_reset), .dut_set(dut_set),
        .j(j), .k(k), .q(q), .qbar(qbar), .clear_stats(clear_stats),
        .model_q(model_q2), .state(state2), .err_flag(err_flag2), .err_count(err_count2),
        .toggle_count(toggle_count2), .cycle_count(cycle_count2), .first_err_cycle(first_err_cycle2)
    );

    // f: 0 correct DUT, 1 q inverted, 2 qbar stuck equal to q
    typedef struct {
        logic r, s, j, k;
        logic [1:0] f;
        logic c;
        logic [1:0] st;
        int ec, tc, cc, fe;
        logic mq;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t v(logic r, s, jj, kk, logic [1:0] f, logic c,
                               logic [1:0] st, int ec, tc, cc, fe, logic mq);
        vec_t x;
        x.r = r; x.s = s; x.j = jj; x.k = kk; x.f = f; x.c = c;
        x.st = st; x.ec = ec; x.tc = tc; x.cc = cc; x.fe = fe; x.mq = mq;
        return x;
    endfunction

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic apply(input vec_t x, input int idx);
        vec_t e;
        dut_reset   = x.r;
        dut_set     = x.s;
        j           = x.j;
        k           = x.k;
        q           = fq ^ (x.f == 2'd1);
        qbar        = (x.f == 2'd2) ? q : ~q;
        clear_stats = x.c;
        sb.push_back(x);
        @(posedge clk);
        fq = x.r ? 1'b0 : x.s ? 1'b1 : (x.j & x.k) ? ~fq : (x.j | x.k) ? x.j : fq;
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d state", idx), int'(state), int'(e.st));
        chk($sformatf("v%0d err_flag", idx), int'(err_flag), int'(e.st == 2'd2));
        chk($sformatf("v%0d err_count", idx), int'(err_count), e.ec);
        chk($sformatf("v%0d toggle_count", idx), int'(toggle_count), e.tc);
        chk($sformatf("v%0d cycle_count", idx), int'(cycle_count), e.cc);
        chk($sformatf("v%0d first_err_cycle", idx), int'(first_err_cycle), e.fe);
        chk($sformatf("v%0d model_q", idx), int'(model_q), int'(e.mq));
    endtask

    task automatic chk_zero(input string n);
        chk({n, " state"}, int'(state), 0);
        chk({n, " err_flag"}, int'(err_flag), 0);
        chk({n, " model_q"}, int'(model_q), 0);
        chk({n, " err_count"}, int'(err_count), 0);
        chk({n, " toggle_count"}, int'(toggle_count), 0);
        chk({n, " cycle_count"}, int'(cycle_count), 0);
        chk({n, " first_err_cycle"}, int'(first_err_cycle), 0);
    endtask

    initial begin
        // idle with no synchronising input
        repeat (5) vecs.push_back(v(0,0,0,0,0,0, 0,0,0,0,0,0));
        // synchronise, then correct DUT through 00,01,10 and 11 x4
        vecs.push_back(v(1,0,0,0,0,0, 1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0, 1,0,0,1,0,0));
        vecs.push_back(v(0,0,0,1,0,0, 1,0,0,2,0,0));
        vecs.push_back(v(0,0,1,0,0,0, 1,0,0,3,0,1));
        vecs.push_back(v(0,0,1,1,0,0, 1,0,1,4,0,0));
        vecs.push_back(v(0,0,1,1,0,0, 1,0,2,5,0,1));
        vecs.push_back(v(0,0,1,1,0,0, 1,0,3,6,0,0));
        vecs.push_back(v(0,0,1,1,0,0, 1,0,4,7,0,1));
        // clear + resync, forced error at cycle 3, then a second error
        vecs.push_back(v(1,0,0,0,0,1, 1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0, 1,0,0,1,0,0));
        vecs.push_back(v(0,0,0,0,0,0, 1,0,0,2,0,0));
        vecs.push_back(v(0,0,0,0,1,0, 2,1,0,3,3,0));
        vecs.push_back(v(0,0,0,0,0,0, 2,1,0,4,3,0));
        vecs.push_back(v(0,0,0,0,1,0, 2,2,0,5,3,0));
        // clear, qbar stuck, clear coincident with mismatch, set then set+reset
        vecs.push_back(v(0,0,0,0,0,1, 1,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,2,0, 2,1,0,1,1,0));
        vecs.push_back(v(0,0,0,0,1,1, 1,0,0,0,0,0));
        vecs.push_back(v(0,1,0,0,0,0, 1,0,0,1,0,1));
        vecs.push_back(v(1,1,1,1,0,0, 1,0,0,2,0,0));
        // five consecutive mismatches
        vecs.push_back(v(0,0,0,0,1,0, 2,1,0,3,3,0));
        vecs.push_back(v(0,0,0,0,1,0, 2,2,0,4,3,0));
        vecs.push_back(v(0,0,0,0,1,0, 2,3,0,5,3,0));
        vecs.push_back(v(0,0,0,0,1,0, 2,4,0,6,3,0));
        vecs.push_back(v(0,0,0,0,1,0, 2,5,0,7,3,0));

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        chk("sat err_count", int'(err_count2), 3);
        chk("sat state", int'(state2), 2);

        // asynchronous reset in the middle of FAULT
        reset = 0;
        #1;
        chk_zero("async_reset");
        chk("async_reset sat err_count", int'(err_count2), 0);
        @(posedge clk);
        #1;
        reset = 1;
        j = 1; k = 1; q = 0; qbar = 1; dut_reset = 0; dut_set = 0; clear_stats = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
